// File: rtl/pb_cond_pkg.sv
// rtl/pb_cond_pkg.sv - shared constants and width helpers for the push-button conditioner
// Contents: channel FSM state encoding, counter width helpers.
package pb_cond_pkg;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_HOLD_DELAY  = 2'd1;
  localparam logic [1:0] ST_HOLD_REPEAT = 2'd2;

  // Bits needed for a counter that runs 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_conditioner_if.sv
// rtl/pb_conditioner_if.sv - button bundle between raw pins, conditioner and mode selector
// Signals: pb_raw (raw levels), pb_level (debounced), pb_pulse (step requests), pb_chord (lockout).
// master: drives pb_raw, observes conditioned outputs. slave: the conditioner.
interface pb_conditioner_if #(
  parameter int N_BTN = 2
) ();
  logic [N_BTN-1:0] pb_raw;
  logic [N_BTN-1:0] pb_level;
  logic [N_BTN-1:0] pb_pulse;
  logic             pb_chord;

  modport master (output pb_raw, input pb_level, input pb_pulse, input pb_chord);
  modport slave  (input pb_raw, output pb_level, output pb_pulse, output pb_chord);
endinterface

// File: rtl/pb_debounce_ch.sv
// rtl/pb_debounce_ch.sv - one button channel: 2-flop sync, counter debounce, press/repeat FSM
// Ports: tp_clk/tp_rst (clock, async active-high reset), pb_raw (raw pin),
//        level (debounced level, registered), raw_pulse (unmasked press/repeat pulse, registered).
module pb_debounce_ch
  import pb_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = 500000,
  parameter int REPEAT_EN        = 1,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 10000000,
  parameter int ACTIVE_LOW       = 0
) (
  input  logic tp_clk,
  input  logic tp_rst,
  input  logic pb_raw,
  output logic level,
  output logic raw_pulse
);

  localparam int DB_W = cnt_w(DEBOUNCE_CYC);
  localparam int RP_W = cnt_w(max2(REPEAT_DELAY_CYC, REPEAT_RATE_CYC));
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] DLY_LAST  = RP_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RP_W-1:0] RATE_LAST = RP_W'(REPEAT_RATE_CYC - 1);

  logic            in_bit;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]      state_q, state_d;
  logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;

  // Polarity is corrected before the synchronizer so reset value 0 is always "released".
  assign in_bit = (ACTIVE_LOW != 0) ? ~pb_raw : pb_raw;

  always_comb begin
    sync1_d  = in_bit;
    sync2_d  = sync1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // The FSM looks at level_d so the press pulse registers on the same edge as the level.
  always_comb begin
    state_d  = state_q;
    rp_cnt_d = rp_cnt_q;
    pulse_d  = 1'b0;
    if (!level_d) begin
      state_d  = ST_IDLE;
      rp_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_HOLD_DELAY;
          rp_cnt_d = '0;
          pulse_d  = 1'b1;
        end
        ST_HOLD_DELAY: begin
          if (rp_cnt_q == DLY_LAST) begin
            // Without repeat the counter parks at its terminal value until release.
            if (REPEAT_EN != 0) begin
              state_d  = ST_HOLD_REPEAT;
              rp_cnt_d = '0;
              pulse_d  = 1'b1;
            end
          end else begin
            rp_cnt_d = rp_cnt_q + RP_W'(1);
          end
        end
        ST_HOLD_REPEAT: begin
          if (rp_cnt_q == RATE_LAST) begin
            rp_cnt_d = '0;
            pulse_d  = 1'b1;
          end else begin
            rp_cnt_d = rp_cnt_q + RP_W'(1);
          end
        end
        default: begin
          state_d  = ST_IDLE;
          rp_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge tp_clk or posedge tp_rst) begin
    if (tp_rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
      db_cnt_q <= '0;
      state_q  <= ST_IDLE;
      rp_cnt_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      rp_cnt_q <= rp_cnt_d;
    end
  end

  assign level     = level_q;
  assign raw_pulse = pulse_q;

endmodule

// File: rtl/pb_conditioner.sv
// rtl/pb_conditioner.sv - push-button conditioner top: per-channel debounce plus chord lockout
// Ports: tp_clk/tp_rst (clock, async active-high reset), pb (slave side of pb_conditioner_if:
//        pb_raw in, pb_level/pb_pulse/pb_chord out).
module pb_conditioner
  import pb_cond_pkg::*;
#(
  parameter int N_BTN            = 2,
  parameter int DEBOUNCE_CYC     = 500000,
  parameter int REPEAT_EN        = 1,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 10000000,
  parameter int ACTIVE_LOW       = 0
) (
  input logic              tp_clk,
  input logic              tp_rst,
  pb_conditioner_if.slave  pb
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] raw_pulse_w;
  logic             lockout_q, lockout_d;
  logic             seen, multi;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    pb_debounce_ch #(
      .DEBOUNCE_CYC     (DEBOUNCE_CYC),
      .REPEAT_EN        (REPEAT_EN),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC  (REPEAT_RATE_CYC),
      .ACTIVE_LOW       (ACTIVE_LOW)
    ) u_ch (
      .tp_clk    (tp_clk),
      .tp_rst    (tp_rst),
      .pb_raw    (pb.pb_raw[g]),
      .level     (level_w[g]),
      .raw_pulse (raw_pulse_w[g])
    );
  end

  // Lockout sets on any multi-press and holds until every button is released.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (level_w[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    lockout_d = multi | (lockout_q & (|level_w));
  end

  always_ff @(posedge tp_clk or posedge tp_rst) begin
    if (tp_rst) lockout_q <= 1'b0;
    else        lockout_q <= lockout_d;
  end

  assign pb.pb_level = level_w;
  // Masking with the next lockout value kills the pulse of the button that forms the chord.
  assign pb.pb_pulse = raw_pulse_w & ~{N_BTN{lockout_d}};
  assign pb.pb_chord = lockout_q;

endmodule

// File: doc/pb_conditioner.md
Name: pb_conditioner

Overview:
- Conditions raw push-button inputs (pb_up, pb_down) before they reach the mood-lighting mode selector.
- Per button: 2-flop synchronization, counter-based debounce, and a one-cycle press pulse with optional hold-to-auto-repeat.
- Adds chord lockout so a simultaneous up+down press never produces step pulses downstream.

Parameters:
- N_BTN, 2, number of button channels; bit 0 = up, bit 1 = down.
- DEBOUNCE_CYC, 500000, consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); must be ≥2.
- REPEAT_EN, 1, 1 enables auto-repeat while held; 0 gives a single pulse per press.
- REPEAT_DELAY_CYC, 25000000, cycles from the press pulse to the first repeat pulse.
- REPEAT_RATE_CYC, 10000000, cycles between subsequent repeat pulses.
- ACTIVE_LOW, 0, 1 inverts pb_raw at the input (pull-up buttons).

Ports:
- tp_clk, in, 1, system clock.
- tp_rst, in, 1, asynchronous active-high reset.
- pb_raw, in, N_BTN, asynchronous raw button levels.
- pb_level, out, N_BTN, debounced pressed level, 1 = pressed.
- pb_pulse, out, N_BTN, one-cycle step request (press or repeat), lockout-masked.
- pb_chord, out, 1, high while lockout is active.

Behaviour:
- Reset (async, tp_rst=1):
  - sync flops load the inactive level.
  - pb_level=0, pb_pulse=0, pb_chord=0.
  - all counters 0, every channel FSM in IDLE.
  - Outputs hold these values for the whole reset assertion. Reset mid-press discards all progress; after release, a still-held button needs a full DEBOUNCE_CYC again.
- Sync: 2 flops per channel, so s = pb_raw (ACTIVE_LOW-corrected) delayed 2 cycles.
- Debounce counter, per channel, width clog2(DEBOUNCE_CYC):
  - Increments each cycle s ≠ pb_level.
  - Clears to 0 any cycle s == pb_level.
  - When it reaches DEBOUNCE_CYC-1 with s ≠ pb_level, pb_level toggles on the next edge and the counter clears.
  - Raw-edge-to-pb_level latency is exactly 2+DEBOUNCE_CYC cycles.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes pb_level.
- Channel FSM states: IDLE, HOLD_DELAY, HOLD_REPEAT.
  - IDLE -> HOLD_DELAY on the pb_level rising edge. The raw press pulse is asserted in the same cycle pb_level first reads 1. The repeat counter loads 0.
  - HOLD_DELAY: the repeat counter increments. When it reaches REPEAT_DELAY_CYC-1 and REPEAT_EN=1: emit a raw pulse next cycle, clear the counter, go to HOLD_REPEAT. With REPEAT_EN=0, stay here until release.
  - HOLD_REPEAT: a raw pulse every REPEAT_RATE_CYC cycles (counter reaches RATE-1, pulse, clear).
  - Any state -> IDLE in the cycle pb_level falls; the counter clears and no pulse is emitted on release.
  - Repeat counter width = clog2(max(REPEAT_DELAY_CYC, REPEAT_RATE_CYC)); it never wraps, it is always cleared at its terminal value.
- Lockout, global register:
  - Set when more than one pb_level bit is 1.
  - Cleared only when all pb_level bits are 0.
  - pb_chord = lockout register.
  - pb_pulse = raw_pulse & ~{N_BTN{lockout_next}}, where lockout_next is the combinational next value. A second button's press pulse is therefore masked in the very cycle the chord forms.
  - After a chord, no pulses occur until everything is released. A fresh single press then behaves normally.
- pb_pulse and pb_level are registered outputs with no combinational path from pb_raw.
- Simultaneous debounced presses in the same cycle produce no pulses and set pb_chord on the next edge.

Decomposition:
- Shared package pb_cond_pkg:
  - FSM state encoding IDLE=2'd0, HOLD_DELAY=2'd1, HOLD_REPEAT=2'd2.
  - Width helper constants for the counters.
- Sub-module pb_debounce_ch: sync + debounce + FSM for one channel, outputs level and raw_pulse.
- The top generates N_BTN instances and holds the lockout register and masking.
- Downstream, pb_pulse[0]/pb_pulse[1] drive the mode-select step inputs in place of the raw buttons.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=8, REPEAT_EN=1):
- Reset: tp_rst asserted mid-cycle with pb_raw=2'b11 -> pb_level=0, pb_pulse=0, pb_chord=0 immediately. After release, pb_level[1:0] rises exactly 6 cycles later and pb_pulse stays 0 because of the chord.
- Clean press of up at cycle T -> pb_level[0]=1 at T+6, pb_pulse[0]=1 for exactly one cycle at T+6; release at R -> pb_level[0]=0 at R+6 with no pulse.
- Bounce: pb_raw[0] toggles with 3-cycle highs and 1-cycle lows for 40 cycles, then holds low -> pb_level[0] never rises and pb_pulse stays 0.
- Hold down for 60 cycles after acceptance at A -> pulses at A, A+20, A+28, A+36, A+44, A+52; none after release. Repeat with REPEAT_EN=0 -> only the pulse at A.
- Chord: up accepted at A (pulse), down accepted at A+5 -> no down pulse, pb_chord=1 from A+6, up repeats suppressed. Release down only -> still no pulses. Release both, then press up -> normal single pulse.
- ACTIVE_LOW=1: pb_raw idles at 1'b1 -> pb_level=0. Drive to 0 -> pb_level[0]=1 and pulse 6 cycles later.
